game_turn_controller: RTL and testbench
=======================================

// Module: game_turn_controller
// PURPOSE
// - Sequences play on the shared game board for two players taking turns.
// - Converts the five raw buttons into single-cycle actions and moves a wrapping
//   cursor over an N_ROWS x N_COLS grid.
// - Issues move requests to the board datapath over a req/ack handshake and
//   keeps per-player move counts.
// - Sits between the button inputs and the board/score datapath in the game top level.
// PARAMETERS
// - N_ROWS   4   grid rows; cursor row range 0..N_ROWS-1
// - N_COLS   4   grid columns; cursor col range 0..N_COLS-1
// - TIMEOUT  50  TURN cycles without a move before the turn is forfeited (>=2)
// - CNT_W    4   width of the per-player move counters
// PORTS
// - clk         in   1                  system clock, rising edge
// - rst         in   1                  asynchronous, active-low reset
// - btnLeft     in   1                  raw button level, synchronous to clk
// - btnRight    in   1                  raw button level, synchronous to clk
// - btnUp       in   1                  raw button level, synchronous to clk
// - btnDown     in   1                  raw button level, synchronous to clk
// - btnSelect   in   1                  raw button level, synchronous to clk
// - brd_req     out  1                  move request to board, held until brd_ack
// - brd_row     out  $clog2(N_ROWS)     requested row (= cur_row, stable while brd_req)
// - brd_col     out  $clog2(N_COLS)     requested col (= cur_col, stable while brd_req)
// - brd_player  out  1                  requesting player: 0 = P1, 1 = P2
// - brd_ack     in   1                  one-cycle board response
// - brd_ok      in   1                  valid with brd_ack: 1 = move accepted, 0 = cell taken
// - game_over   in   1                  board level flag: win or grid full
// - cur_row     out  $clog2(N_ROWS)     cursor row
// - cur_col     out  $clog2(N_COLS)     cursor col
// - player      out  1                  player whose turn it is
// - state       out  2                  current FSM state (package enum)
// - timeout_p   out  1                  one-cycle pulse when a turn is forfeited
// - moves1      out  CNT_W              accepted moves, P1, saturating
// - moves2      out  CNT_W              accepted moves, P2, saturating
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, cursor=(0,0), player=0, brd_req=0, timeout_p=0,
//   moves1=moves2=0, turn timer=0, all previous-button registers=0.
// - Buttons: rising edge only, edge = btn & ~btn_q (btn_q is last cycle's level).
//   At most one action per cycle, priority Select > Left > Right > Up > Down.
//   Held buttons act once. Edges are ignored in REQ and DONE, except Select in DONE.
// - IDLE: Select edge -> TURN, timer=0.
// - TURN, in priority order:
//   1. game_over=1 -> DONE.
//   2. Select edge -> REQ; brd_req=1 from the next cycle.
//   3. timer==TIMEOUT-1 -> toggle player, timer=0, timeout_p=1 for one cycle,
//      cursor unchanged.
//   4. Otherwise: direction edge moves the cursor; timer increments.
// - Cursor moves wrap around: Left at col 0 -> N_COLS-1, Right at N_COLS-1 -> 0,
//   Up at row 0 -> N_ROWS-1, Down at N_ROWS-1 -> 0.
// - REQ: brd_req=1; brd_row, brd_col and brd_player are frozen. Timer is held.
//   On brd_ack: brd_req=0 the next cycle; state -> TURN.
//   - brd_ok=1: increment the current player's counter (saturates at 2^CNT_W-1),
//     toggle player, timer=0.
//   - brd_ok=0: same player keeps the turn; timer resumes from its held value.
// - Select on the timeout cycle: Select wins, no forfeit.
// - brd_ack outside REQ is ignored.
// - DONE: outputs hold. Select edge -> IDLE, clearing moves1, moves2, player and cursor.
// - Reset asserted mid-REQ drops brd_req immediately (async).
// STRUCTURE
// - Package game_pkg:
//   - state_t enum {IDLE=2'd0, TURN=2'd1, REQ=2'd2, DONE=2'd3}
//   - player_t (P1=1'b0, P2=1'b1)
//   - action_t enum {ACT_NONE, ACT_SEL, ACT_L, ACT_R, ACT_U, ACT_D}
// - Sub-module btn_edge_detect #(W=5): per-bit rising-edge registers with the same
//   async active-low reset; the priority encoder stays in this module.
// TESTING
// - Reset, Select pulse: state IDLE->TURN; Left pulse -> cur_col=3; Up pulse -> cur_row=3.
// - Select held high for 5 cycles in TURN: exactly one REQ. Board acks ok on the 3rd
//   REQ cycle: brd_req high 3 cycles, moves1=1, player=1.
// - REQ answered with brd_ack=1, brd_ok=0: player stays 0, moves1=0, TURN resumes.
// - TIMEOUT=50, no buttons in TURN: timeout_p pulses on cycle 50 and player toggles.
//   Select on that exact cycle: no pulse, REQ entered.
// - Same-cycle edges on Left and Right: only Left applied, cur_col 0->3.
//   Left+Select: REQ, cursor unchanged.
// - game_over=1 in TURN -> DONE; buttons ignored; Select -> IDLE with moves1=moves2=0.
//   Reset mid-REQ: brd_req=0 without a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the game turn controller: FSM states, player ids and the
// decoded single-cycle button actions.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_SEL  = 3'd1,
    ACT_L    = 3'd2,
    ACT_R    = 3'd3,
    ACT_U    = 3'd4,
    ACT_D    = 3'd5
  } action_t;

  // Bit positions inside the packed button vector {select, left, right, up, down}
  localparam int BTN_W   = 5;
  localparam int BTN_SEL = 4;
  localparam int BTN_L   = 3;
  localparam int BTN_R   = 2;
  localparam int BTN_U   = 1;
  localparam int BTN_D   = 0;

endpackage

// File: rtl/game_turn_controller_btn_edge_detect.sv
// Rising-edge detection for a bank of button levels that are already
// synchronous to clk; one previous-level register per button.
module btn_edge_detect
  import game_pkg::*;
#(
  parameter int W = BTN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] btn_q_r;

  // Previous-cycle button levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q_r <= {W{1'b0}};
    end else begin
      btn_q_r <= btn;
    end
  end

  assign rise = btn & ~btn_q_r;

endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencer for a two-player grid game: button actions, wrapping cursor,
// board move handshake, turn timeout and per-player move counting.
module game_turn_controller
  import game_pkg::*;
#(
  parameter int N_ROWS  = 4,
  parameter int N_COLS  = 4,
  parameter int TIMEOUT = 50,
  parameter int CNT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btnLeft,
  input  logic                      btnRight,
  input  logic                      btnUp,
  input  logic                      btnDown,
  input  logic                      btnSelect,
  output logic                      brd_req,
  output logic [$clog2(N_ROWS)-1:0] brd_row,
  output logic [$clog2(N_COLS)-1:0] brd_col,
  output logic                      brd_player,
  input  logic                      brd_ack,
  input  logic                      brd_ok,
  input  logic                      game_over,
  output logic [$clog2(N_ROWS)-1:0] cur_row,
  output logic [$clog2(N_COLS)-1:0] cur_col,
  output logic                      player,
  output state_t                    state,
  output logic                      timeout_p,
  output logic [CNT_W-1:0]          moves1,
  output logic [CNT_W-1:0]          moves2
);

  localparam int RW = $clog2(N_ROWS);
  localparam int CW = $clog2(N_COLS);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [RW-1:0]    ROW_MAX    = RW'(N_ROWS - 1);
  localparam logic [CW-1:0]    COL_MAX    = CW'(N_COLS - 1);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [BTN_W-1:0] btn_s;
  logic [BTN_W-1:0] rise_s;
  action_t          act_s;

  state_t           state_r, state_n;
  logic [RW-1:0]    row_r, row_n;
  logic [CW-1:0]    col_r, col_n;
  logic             player_r, player_n;
  logic [TW-1:0]    timer_r, timer_n;
  logic [CNT_W-1:0] moves1_r, moves1_n;
  logic [CNT_W-1:0] moves2_r, moves2_n;
  logic             timeout_n;
  logic             brd_req_r;
  logic             timeout_p_r;

  assign btn_s = {btnSelect, btnLeft, btnRight, btnUp, btnDown};

  btn_edge_detect #(
    .W (BTN_W)
  ) u_btn_edge (
    .clk   (clk),
    .rst_n (rst),
    .btn   (btn_s),
    .rise  (rise_s)
  );

  // One action per cycle, Select first, then Left, Right, Up, Down
  always_comb begin
    act_s = ACT_NONE;
    if (rise_s[BTN_SEL]) begin
      act_s = ACT_SEL;
    end else if (rise_s[BTN_L]) begin
      act_s = ACT_L;
    end else if (rise_s[BTN_R]) begin
      act_s = ACT_R;
    end else if (rise_s[BTN_U]) begin
      act_s = ACT_U;
    end else if (rise_s[BTN_D]) begin
      act_s = ACT_D;
    end else begin
      act_s = ACT_NONE;
    end
  end

  // Next-state, cursor, timer and counter logic
  always_comb begin
    state_n   = state_r;
    row_n     = row_r;
    col_n     = col_r;
    player_n  = player_r;
    timer_n   = timer_r;
    moves1_n  = moves1_r;
    moves2_n  = moves2_r;
    timeout_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (act_s == ACT_SEL) begin
          state_n = TURN;
          timer_n = {TW{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      TURN: begin
        if (game_over) begin
          state_n = DONE;
        end else if (act_s == ACT_SEL) begin
          state_n = REQ;
        end else if (timer_r == TIMER_LAST) begin
          player_n  = ~player_r;
          timer_n   = {TW{1'b0}};
          timeout_n = 1'b1;
        end else begin
          timer_n = timer_r + TW'(1);
          case (act_s)
            ACT_L:   col_n = (col_r == {CW{1'b0}}) ? COL_MAX : col_r - CW'(1);
            ACT_R:   col_n = (col_r == COL_MAX) ? {CW{1'b0}} : col_r + CW'(1);
            ACT_U:   row_n = (row_r == {RW{1'b0}}) ? ROW_MAX : row_r - RW'(1);
            ACT_D:   row_n = (row_r == ROW_MAX) ? {RW{1'b0}} : row_r + RW'(1);
            default: row_n = row_r;
          endcase
        end
      end
      REQ: begin
        // Timer stays frozen here; a rejected move resumes the same turn clock
        if (brd_ack) begin
          state_n = TURN;
          if (brd_ok) begin
            player_n = ~player_r;
            timer_n  = {TW{1'b0}};
            if (player_r == P1) begin
              moves1_n = (moves1_r == CNT_MAX) ? moves1_r : moves1_r + CNT_W'(1);
            end else begin
              moves2_n = (moves2_r == CNT_MAX) ? moves2_r : moves2_r + CNT_W'(1);
            end
          end else begin
            timer_n = timer_r;
          end
        end else begin
          state_n = REQ;
        end
      end
      DONE: begin
        if (act_s == ACT_SEL) begin
          state_n  = IDLE;
          row_n    = {RW{1'b0}};
          col_n    = {CW{1'b0}};
          player_n = P1;
          timer_n  = {TW{1'b0}};
          moves1_n = {CNT_W{1'b0}};
          moves2_n = {CNT_W{1'b0}};
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers; brd_req mirrors entry into REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      row_r       <= {RW{1'b0}};
      col_r       <= {CW{1'b0}};
      player_r    <= P1;
      timer_r     <= {TW{1'b0}};
      moves1_r    <= {CNT_W{1'b0}};
      moves2_r    <= {CNT_W{1'b0}};
      brd_req_r   <= 1'b0;
      timeout_p_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      row_r       <= row_n;
      col_r       <= col_n;
      player_r    <= player_n;
      timer_r     <= timer_n;
      moves1_r    <= moves1_n;
      moves2_r    <= moves2_n;
      brd_req_r   <= (state_n == REQ);
      timeout_p_r <= timeout_n;
    end
  end

  assign state      = state_r;
  assign cur_row    = row_r;
  assign cur_col    = col_r;
  assign player     = player_r;
  assign brd_req    = brd_req_r;
  assign brd_row    = row_r;
  assign brd_col    = col_r;
  assign brd_player = player_r;
  assign timeout_p  = timeout_p_r;
  assign moves1     = moves1_r;
  assign moves2     = moves2_r;

endmodule

// File: tb/tb_game_turn_controller.sv
// Scoreboard bench for game_turn_controller: stimulus queues expected output
// snapshots, a negedge monitor pops and compares them.
module tb_game_turn_controller;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btnLeft = 1'b0, btnRight = 1'b0, btnUp = 1'b0, btnDown = 1'b0, btnSelect = 1'b0;
  logic       brd_ack = 1'b0, brd_ok = 1'b0, game_over = 1'b0;
  logic       brd_req, brd_player, player, timeout_p;
  logic [1:0] brd_row, brd_col, cur_row, cur_col;
  state_t     state;
  logic [3:0] moves1, moves2;

  localparam logic [4:0] B_0   = 5'b00000;
  localparam logic [4:0] B_SEL = 5'b10000;
  localparam logic [4:0] B_L   = 5'b01000;
  localparam logic [4:0] B_R   = 5'b00100;
  localparam logic [4:0] B_U   = 5'b00010;
  localparam logic [4:0] B_D   = 5'b00001;

  game_turn_controller #(
    .N_ROWS (4), .N_COLS (4), .TIMEOUT (50), .CNT_W (4)
  ) dut (
    .clk (clk), .rst (rst),
    .btnLeft (btnLeft), .btnRight (btnRight), .btnUp (btnUp), .btnDown (btnDown),
    .btnSelect (btnSelect),
    .brd_req (brd_req), .brd_row (brd_row), .brd_col (brd_col), .brd_player (brd_player),
    .brd_ack (brd_ack), .brd_ok (brd_ok), .game_over (game_over),
    .cur_row (cur_row), .cur_col (cur_col), .player (player), .state (state),
    .timeout_p (timeout_p), .moves1 (moves1), .moves2 (moves2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          due;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected snapshot {state,row,col,player,req,timeout_p,moves1,moves2}
  task automatic expect_snap(input string n, input logic [1:0] st, input logic [1:0] r,
                             input logic [1:0] c, input logic pl, input logic rq,
                             input logic tp, input logic [3:0] m1, input logic [3:0] m2);
    exp_t e;
    e.name = n;
    e.due  = cyc;
    e.v    = {st, r, c, pl, rq, tp, m1, m2};
    q.push_back(e);
  endtask

  task automatic step(input logic [4:0] b, input logic ack, input logic ok, input logic go);
    {btnSelect, btnLeft, btnRight, btnUp, btnDown} = b;
    brd_ack   = ack;
    brd_ok    = ok;
    game_over = go;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every snapshot due in the current cycle
  exp_t        cur_e;
  logic [16:0] act_v;
  always @(negedge clk) begin
    act_v = {state, cur_row, cur_col, player, brd_req, timeout_p, moves1, moves2};
    while (q.size() > 0 && q[0].due <= cyc) begin
      cur_e = q.pop_front();
      n_checks++;
      if (cur_e.due == cyc && act_v == cur_e.v) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got %05h required %05h (st,row,col,pl,req,tp,m1,m2) due=%0d cyc=%0d",
                 cur_e.name, act_v, cur_e.v, cur_e.due, cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_snap("reset", IDLE, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;

    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("idle_to_turn", TURN, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_L, 1'b0, 1'b0, 1'b0);
    expect_snap("left_wrap", TURN, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    n_checks++;
    if (cur_col === 2'd3) begin
      n_pass++;
    end else begin
      $display("FAIL left_wrap_direct: got cur_col=%0d required 3", cur_col);
    end
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_U, 1'b0, 1'b0, 1'b0);
    expect_snap("up_wrap", TURN, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(B_0, 1'b0, 1'b0, 1'b0);

    // Select held for five cycles, board accepts on the third REQ cycle
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("req_c1", REQ, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("req_c2", REQ, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("req_c3", REQ, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(B_SEL, 1'b1, 1'b1, 1'b0);
    expect_snap("ack_ok_p1", TURN, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("held_sel_once", TURN, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
    step(B_0, 1'b0, 1'b0, 1'b0);

    // Rejected move keeps the turn
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("req_p2", REQ, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0);
    step(B_0, 1'b1, 1'b0, 1'b0);
    expect_snap("ack_reject", TURN, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
    step(B_0, 1'b1, 1'b1, 1'b0);
    expect_snap("ack_outside_req", TURN, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);

    step(B_L | B_R, 1'b0, 1'b0, 1'b0);
    expect_snap("left_right_same", TURN, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_L | B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("left_sel_same", REQ, 2'd3, 2'd2, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0);
    step(B_0, 1'b1, 1'b1, 1'b0);
    expect_snap("ack_ok_p2", TURN, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);

    // Turn timeout: 49 idle cycles, forfeit on the 50th
    for (int i = 0; i < 49; i++) step(B_0, 1'b0, 1'b0, 1'b0);
    expect_snap("pre_timeout", TURN, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1);
    step(B_0, 1'b0, 1'b0, 1'b0);
    expect_snap("timeout", TURN, 2'd3, 2'd2, 1'b1, 1'b0, 1'b1, 4'd1, 4'd1);
    step(B_0, 1'b0, 1'b0, 1'b0);
    expect_snap("timeout_one_cycle", TURN, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);

    // Select on the forfeit cycle wins
    for (int i = 0; i < 48; i++) step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("sel_on_timeout", REQ, 2'd3, 2'd2, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
    step(B_0, 1'b1, 1'b1, 1'b0);
    expect_snap("ack_ok_p2b", TURN, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);

    step(B_D, 1'b0, 1'b0, 1'b0);
    expect_snap("down_wrap", TURN, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_R, 1'b0, 1'b0, 1'b0);
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_R, 1'b0, 1'b0, 1'b0);
    expect_snap("right_wrap", TURN, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_U, 1'b0, 1'b0, 1'b0);

    // Game over, buttons ignored, Select clears back to IDLE
    step(B_0, 1'b0, 1'b0, 1'b1);
    expect_snap("game_over", DONE, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    step(B_L, 1'b0, 1'b0, 1'b1);
    expect_snap("done_ignores_dir", DONE, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("done_to_idle", IDLE, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_L, 1'b0, 1'b0, 1'b0);
    expect_snap("idle_ignores_dir", IDLE, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Asynchronous reset while a request is outstanding
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    step(B_0, 1'b0, 1'b0, 1'b0);
    step(B_SEL, 1'b0, 1'b0, 1'b0);
    expect_snap("req_before_reset", REQ, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    step(B_0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    n_checks++;
    if (brd_req === 1'b0) begin
      n_pass++;
    end else begin
      $display("FAIL async_reset_direct: got brd_req=%b required 0", brd_req);
    end
    expect_snap("async_reset", IDLE, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    step(B_0, 1'b0, 1'b0, 1'b0);
    expect_snap("post_reset_idle", IDLE, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    n_checks++;
    if (state === IDLE) begin
      n_pass++;
    end else begin
      $display("FAIL post_reset_direct: got state=%0d required IDLE", state);
    end

    step(B_0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      cur_e = q.pop_front();
      n_checks++;
      $display("FAIL %s: got no comparison required one at cycle %0d", cur_e.name, cur_e.due);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    if (n_pass == n_checks) begin
      $display("PASS");
    end else begin
      $display("FAIL summary: %0d of %0d checks failed", n_checks - n_pass, n_checks);
    end
    $finish;
  end

endmodule
